// File: rtl/pre_if_stage.sv
// Pre-IF stage: fetches one instruction at a time from the SRAM-like bus and holds it
// in a single-entry buffer. Redirects override the fetch PC in any state.
module pre_if_stage (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic [32:0] br_bus,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ex_ra,
    input  logic        if_allowin,
    output logic        preif_to_if_valid,
    output logic [79:0] preif_to_if_bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_FULL = 2'b10
    } state_t;

    localparam logic [31:0] RESET_PC   = 32'h1C00_0000;
    localparam logic [14:0] ADEF_CODE  = 15'h0008;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_nxt_s;
    logic [31:0] pc_seq_s;
    logic        cancel_r;
    logic        cancel_nxt_s;
    logic [31:0] buf_pc_r;
    logic [31:0] buf_pc_nxt_s;
    logic [31:0] buf_inst_r;
    logic [31:0] buf_inst_nxt_s;
    logic        buf_ex_r;
    logic        buf_ex_nxt_s;
    logic [14:0] buf_ex_code_r;
    logic [14:0] buf_ex_code_nxt_s;

    logic        br_taken_s;
    logic [31:0] br_target_s;
    logic        redirect_s;
    logic [31:0] redirect_target_s;
    logic        pc_aligned_s;
    logic        addr_accept_s;

    assign br_taken_s        = br_bus[0];
    assign br_target_s       = br_bus[32:1];
    assign redirect_s        = wb_ex | ertn_flush | br_taken_s;
    assign redirect_target_s = wb_ex      ? ex_entry :
                               ertn_flush ? ex_ra    : br_target_s;
    assign pc_aligned_s      = (fetch_pc_r[1:0] == 2'b00);

    // Request is masked while resetn is low so the bus sees nothing during reset.
    assign inst_sram_req     = resetn & (state_r == S_REQ) & pc_aligned_s;
    assign addr_accept_s     = inst_sram_req & inst_sram_addr_ok;

    assign inst_sram_wr      = 1'b0;
    assign inst_sram_size    = 2'b10;
    assign inst_sram_wstrb   = 4'b0000;
    assign inst_sram_wdata   = 32'h0000_0000;
    assign inst_sram_addr    = fetch_pc_r;

    assign preif_to_if_valid = (state_r == S_FULL) & ~redirect_s;
    assign preif_to_if_bus   = {buf_pc_r, buf_inst_r, buf_ex_r, buf_ex_code_r};

    // Next-state, fetch PC, cancel flag and buffer update.
    always_comb begin
        state_nxt_s       = state_r;
        pc_seq_s          = fetch_pc_r;
        cancel_nxt_s      = cancel_r;
        buf_pc_nxt_s      = buf_pc_r;
        buf_inst_nxt_s    = buf_inst_r;
        buf_ex_nxt_s      = buf_ex_r;
        buf_ex_code_nxt_s = buf_ex_code_r;
        case (state_r)
            S_REQ: begin
                if (addr_accept_s) begin
                    state_nxt_s  = S_WAIT;
                    cancel_nxt_s = redirect_s;
                end else if (!pc_aligned_s && !redirect_s) begin
                    // Misaligned fetch never reaches the bus; deliver an ADEF entry instead.
                    state_nxt_s       = S_FULL;
                    buf_pc_nxt_s      = fetch_pc_r;
                    buf_inst_nxt_s    = 32'h0000_0000;
                    buf_ex_nxt_s      = 1'b1;
                    buf_ex_code_nxt_s = ADEF_CODE;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (cancel_r || redirect_s) begin
                        state_nxt_s  = S_REQ;
                        cancel_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s       = S_FULL;
                        buf_pc_nxt_s      = fetch_pc_r;
                        buf_inst_nxt_s    = inst_sram_rdata;
                        buf_ex_nxt_s      = 1'b0;
                        buf_ex_code_nxt_s = 15'h0000;
                    end
                end else if (redirect_s) begin
                    cancel_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_FULL: begin
                if (redirect_s) begin
                    state_nxt_s = S_REQ;
                end else if (if_allowin) begin
                    state_nxt_s = S_REQ;
                    pc_seq_s    = fetch_pc_r + 32'd4;
                end else begin
                    state_nxt_s = S_FULL;
                end
            end
            default: begin
                state_nxt_s  = S_REQ;
                cancel_nxt_s = 1'b0;
            end
        endcase
        fetch_pc_nxt_s = redirect_s ? redirect_target_s : pc_seq_s;
    end

    // State and buffer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= S_REQ;
            fetch_pc_r    <= RESET_PC;
            cancel_r      <= 1'b0;
            buf_pc_r      <= 32'h0000_0000;
            buf_inst_r    <= 32'h0000_0000;
            buf_ex_r      <= 1'b0;
            buf_ex_code_r <= 15'h0000;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            cancel_r      <= cancel_nxt_s;
            buf_pc_r      <= buf_pc_nxt_s;
            buf_inst_r    <= buf_inst_nxt_s;
            buf_ex_r      <= buf_ex_nxt_s;
            buf_ex_code_r <= buf_ex_code_nxt_s;
        end
    end

endmodule
